// File: rtl/polymul_writeback_packer.sv
// polymul_writeback_packer: packs butterfly result pairs into 128-bit BRAM words and generates
// the write address sequence for forward NTT, inverse NTT and element-wise passes.
// Optional macro POLYMUL_WB_OUTREG_EN adds one output register stage on write_address, wea,
// data128_out and done; busy is stretched so it still falls the cycle after the delayed done.
module polymul_writeback_packer #(
  parameter int unsigned NTT_WORDS = 1024,
  parameter int unsigned EW_WORDS  = 256,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  input  logic [63:0]       result_a,
  input  logic [63:0]       result_b,
  output logic [ADDR_W-1:0] write_address,
  output logic              wea,
  output logic [127:0]      data128_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned RevW = $clog2(NTT_WORDS);
  localparam logic [ADDR_W-1:0] LastNtt = ADDR_W'(NTT_WORDS - 1);
  localparam logic [ADDR_W-1:0] LastEw  = ADDR_W'(EW_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              r_state;
  logic                r_mode_ew;   // element-wise pass (mode 10 or 11)
  logic                r_mode_inv;  // inverse NTT pass (bit-reversed addresses)
  logic [ADDR_W-1:0]   r_wcnt;
  logic                r_half;
  logic [63:0]         r_held;
  logic                r_fin;       // final word written; RUN moves to DONE next cycle
  logic                r_wea;
  logic [ADDR_W-1:0]   r_addr;
  logic [127:0]        r_data;
  logic                r_busy;
  logic                r_done;

  logic [ADDR_W-1:0]   w_rev;
  logic                w_ntt_last;
  logic                w_ew_last;

  // Bit-reverse wcnt over log2(NTT_WORDS) bits, zero-extended to ADDR_W (pure rewiring)
  always_comb begin
    w_rev = '0;
    for (int i = 0; i < int'(RevW); i++) begin
      w_rev[i] = r_wcnt[int'(RevW) - 1 - i];
    end
  end

  assign w_ntt_last = (r_wcnt == LastNtt);
  assign w_ew_last  = (r_wcnt == LastEw);

  // Pass FSM with word counter, element-wise half-word packing and registered BRAM outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_mode_ew  <= 1'b0;
      r_mode_inv <= 1'b0;
      r_wcnt     <= '0;
      r_half     <= 1'b0;
      r_held     <= '0;
      r_fin      <= 1'b0;
      r_wea      <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_wea  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_state    <= StRun;
            r_busy     <= 1'b1;
            r_mode_ew  <= mode[1];
            r_mode_inv <= (mode == 2'b01);
            r_wcnt     <= '0;
            r_half     <= 1'b0;
            r_held     <= '0;
            r_fin      <= 1'b0;
          end
        end
        StRun: begin
          if (r_fin) begin
            // Valids arriving here belong to no pass and are dropped
            r_state <= StDone;
            r_done  <= 1'b1;
            r_fin   <= 1'b0;
          end else if (in_valid) begin
            if (r_mode_ew) begin
              if (!r_half) begin
                r_held <= result_a;
                r_half <= 1'b1;
              end else begin
                r_half <= 1'b0;
                r_wea  <= 1'b1;
                r_addr <= r_wcnt;
                r_data <= {result_a, r_held};
                if (w_ew_last) begin
                  r_wcnt <= '0;
                  r_fin  <= 1'b1;
                end else begin
                  r_wcnt <= r_wcnt + 1'b1;
                end
              end
            end else begin
              r_wea  <= 1'b1;
              r_addr <= r_mode_inv ? w_rev : r_wcnt;
              r_data <= {result_b, result_a};
              if (w_ntt_last) begin
                r_wcnt <= '0;
                r_fin  <= 1'b1;
              end else begin
                r_wcnt <= r_wcnt + 1'b1;
              end
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef POLYMUL_WB_OUTREG_EN
  logic                r_wea_q;
  logic [ADDR_W-1:0]   r_addr_q;
  logic [127:0]        r_data_q;
  logic                r_done_q;

  // Extra output stage; busy covers the delayed done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wea_q  <= 1'b0;
      r_addr_q <= '0;
      r_data_q <= '0;
      r_done_q <= 1'b0;
    end else begin
      r_wea_q  <= r_wea;
      r_addr_q <= r_addr;
      r_data_q <= r_data;
      r_done_q <= r_done;
    end
  end

  assign wea           = r_wea_q;
  assign write_address = r_addr_q;
  assign data128_out   = r_data_q;
  assign done          = r_done_q;
  assign busy          = r_busy | r_done_q;
`else
  assign wea           = r_wea;
  assign write_address = r_addr;
  assign data128_out   = r_data;
  assign done          = r_done;
  assign busy          = r_busy;
`endif

endmodule

// File: tb/tb_polymul_writeback_packer.sv
// Directed bench for polymul_writeback_packer: forward, inverse, element-wise, gapped input,
// mid-pass reset and ignored start/in_valid events. Honours POLYMUL_WB_OUTREG_EN latency.
module tb_polymul_writeback_packer;

  localparam int unsigned AW = 10;
`ifdef POLYMUL_WB_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [1:0]     mode = 2'b00;
  logic           in_valid = 1'b0;
  logic [63:0]    ra = '0;
  logic [63:0]    rb = '0;
  logic [AW-1:0]  write_address;
  logic           wea;
  logic [127:0]   data128_out;
  logic           busy;
  logic           done;

  polymul_writeback_packer #(
    .NTT_WORDS (1024),
    .EW_WORDS  (256),
    .ADDR_W    (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mode          (mode),
    .in_valid      (in_valid),
    .result_a      (ra),
    .result_b      (rb),
    .write_address (write_address),
    .wea           (wea),
    .data128_out   (data128_out),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] wr_addr[$];
  logic [127:0]  wr_data[$];
  int            wr_cyc[$];
  int            done_cyc[$];
  int            fall_cyc[$];
  int            v_cyc[$];
  logic          busy_prev = 1'b0;

  // Log writes, done pulses and busy falling edges away from the active edge
  always @(negedge clk) begin
    if (wea === 1'b1) begin
      wr_addr.push_back(write_address);
      wr_data.push_back(data128_out);
      wr_cyc.push_back(cyc);
    end
    if (done === 1'b1) done_cyc.push_back(cyc);
    if (busy_prev === 1'b1 && busy === 1'b0) fall_cyc.push_back(cyc);
    busy_prev = busy;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b);
    in_valid = 1'b1;
    ra = a;
    rb = b;
    v_cyc.push_back(cyc + 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic clear_logs();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cyc.delete();
    fall_cyc.delete();
    v_cyc.delete();
  endtask

  task automatic begin_pass(input logic [1:0] m);
    clear_logs();
    mode = m;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  function automatic logic [AW-1:0] bitrev10(input int i);
    logic [AW-1:0] v;
    logic [AW-1:0] r;
    v = i[AW-1:0];
    for (int k = 0; k < int'(AW); k++) r[k] = v[int'(AW) - 1 - k];
    return r;
  endfunction

  // Completion timing common to every pass: done once, LAT after final valid, busy falls after
  task automatic chk_done(input string tag, input int last_v);
    int dc;
    chk({tag, "_done_count"}, done_cyc.size(), 1);
    dc = (done_cyc.size() > 0) ? done_cyc[0] : -1;
    chk({tag, "_done_cycle"}, dc, last_v + LAT);
    chk({tag, "_busy_fall"}, (fall_cyc.size() > 0) ? fall_cyc[0] : -1, dc + 1);
  endtask

  task automatic chk_fwd(input string tag);
    int nbad;
    logic [127:0] exp;
    chk({tag, "_count"}, wr_addr.size(), 1024);
    nbad = 0;
    for (int i = 0; i < wr_addr.size() && i < 1024; i++) begin
      exp = {64'(i + 'h1000), 64'(i)};
      if (wr_addr[i] !== i[AW-1:0] || wr_data[i] !== exp || wr_cyc[i] !== v_cyc[i] + LAT - 1)
        nbad++;
    end
    chk({tag, "_seq"}, nbad, 0);
    chk_done(tag, v_cyc[1023]);
  endtask

  task automatic chk_ew(input string tag);
    int nbad;
    logic [127:0] exp;
    chk({tag, "_count"}, wr_addr.size(), 256);
    nbad = 0;
    for (int j = 0; j < wr_addr.size() && j < 256; j++) begin
      exp = {64'(2 * j + 1), 64'(2 * j)};
      if (wr_addr[j] !== j[AW-1:0] || wr_data[j] !== exp ||
          wr_cyc[j] !== v_cyc[2 * j + 1] + LAT - 1)
        nbad++;
    end
    chk({tag, "_seq"}, nbad, 0);
    chk_done(tag, v_cyc[511]);
  endtask

  initial begin
    int nbad;
    int hits[1024];

    // Reset state
    repeat (3) step();
    chk("rst_wea", wea, 0);
    chk("rst_addr", write_address, 0);
    chk("rst_data", data128_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    step();

    // Forward NTT, contiguous
    begin_pass(2'b00);
    chk("fwd_busy_rise", busy, 1);
    for (int i = 0; i < 1024; i++) drive(64'(i), 64'(i + 'h1000));
    repeat (6) step();
    chk_fwd("fwd");
    chk("fwd_idle_busy", busy, 0);

    // Inverse NTT, bit-reversed addresses
    begin_pass(2'b01);
    for (int i = 0; i < 1024; i++) drive(64'(i), 64'(2 * i));
    repeat (6) step();
    chk("inv_count", wr_addr.size(), 1024);
    chk("inv_addr1", wr_addr[1], 'h200);
    chk("inv_data1", wr_data[1], {64'd2, 64'd1});
    chk("inv_addr3", wr_addr[3], 'h300);
    nbad = 0;
    for (int i = 0; i < 1024; i++) hits[i] = 0;
    for (int i = 0; i < wr_addr.size() && i < 1024; i++) begin
      hits[wr_addr[i]]++;
      if (wr_addr[i] !== bitrev10(i) || wr_data[i] !== {64'(2 * i), 64'(i)}) nbad++;
    end
    for (int i = 0; i < 1024; i++) if (hits[i] != 1) nbad++;
    chk("inv_seq_cover", nbad, 0);
    chk_done("inv", v_cyc[1023]);

    // Element-wise; result_b toggles and must not matter
    begin_pass(2'b10);
    for (int k = 0; k < 512; k++) drive(64'(k), (k % 2 == 0) ? '1 : 64'h5a5a);
    repeat (6) step();
    chk_ew("ew");

    // Forward NTT with gaps
    begin_pass(2'b00);
    for (int i = 0; i < 1024; i++) begin
      drive(64'(i), 64'(i + 'h1000));
      repeat (2 + $urandom_range(0, 2)) step();
    end
    repeat (6) step();
    chk_fwd("gap");

    // Reset mid-pass; mode 11 behaves as element-wise
    begin_pass(2'b11);
    drive(64'd100, 64'd7);
    drive(64'd101, 64'd8);
    drive(64'd102, 64'd9);
    rst = 1'b1;
    step();
    chk("m11_count", wr_addr.size(), 1);
    chk("m11_data", wr_data[0], {64'd101, 64'd100});
    chk("midrst_wea", wea, 0);
    chk("midrst_addr", write_address, 0);
    chk("midrst_data", data128_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    rst = 1'b0;
    step();
    begin_pass(2'b10);
    for (int k = 0; k < 512; k++) drive(64'(k), 64'(k * 3));
    repeat (6) step();
    chk("post_rst_word0", wr_data[0], {64'd1, 64'd0});
    chk_ew("post_rst");

    // in_valid in IDLE: no writes, no pass
    clear_logs();
    for (int k = 0; k < 4; k++) drive(64'hdead, 64'hbeef);
    step();
    chk("idle_valid_writes", wr_addr.size(), 0);
    chk("idle_valid_busy", busy, 0);

    // start (with different mode) during RUN ignored; start during DONE ignored
    begin_pass(2'b00);
    drive(64'd0, 64'h1000);
    drive(64'd1, 64'h1001);
    mode = 2'b01;
    start = 1'b1;
    step();
    start = 1'b0;
    mode = 2'b00;
    for (int i = 2; i < 1024; i++) drive(64'(i), 64'(i + 'h1000));
    step();
    mode = 2'b01;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    chk_fwd("ign");
    chk("ign_done_start_busy", busy, 0);
    for (int k = 0; k < 3; k++) drive(64'h77, 64'h88);
    step();
    chk("ign_done_start_writes", wr_addr.size(), 1024);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
